// File: rtl/dmem_responder_if.sv
// Request/response bus between the execution unit (master) and the
// data-memory responder (slave).
interface dmem_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] RAM_Address;
  logic [31:0] Data_to_RAM;
  logic [31:0] Data_from_RAM;
  logic        Ready;
  logic        Stall;
  logic        AddrError;

  modport master (
    output MemRead, MemWrite, RAM_Address, Data_to_RAM,
    input  Data_from_RAM, Ready, Stall, AddrError
  );

  modport slave (
    input  MemRead, MemWrite, RAM_Address, Data_to_RAM,
    output Data_from_RAM, Ready, Stall, AddrError
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory behind a request/ready handshake with a fixed
// number of wait states. Misaligned, out-of-range and read+write requests
// complete with AddrError instead of touching the array.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);

  localparam int          LP_AW    = $clog2(DEPTH_WORDS);
  localparam logic [31:0] LP_DEPTH = 32'(DEPTH_WORDS);
  localparam logic [3:0]  LP_WAIT  = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [3:0]         r_cnt;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic               r_rd;
  logic               r_wr;
  logic [31:0]        r_dout;
  logic               r_ready;
  logic               r_addr_err;
  logic [31:0]        r_mem [DEPTH_WORDS];

  logic               w_req;
  logic               w_access;
  logic               w_err;
  logic [LP_AW-1:0]   w_index;

  assign w_req    = bus.MemRead | bus.MemWrite;
  assign w_access = (r_state == ST_BUSY) && (r_cnt == 4'd0);
  assign w_index  = r_addr[LP_AW+1:2];
  // Error is judged on the latched request only; live inputs are ignored
  // once the transaction has been accepted.
  assign w_err    = (r_rd & r_wr)
                  | (r_addr[1:0] != 2'b00)
                  | ({2'b00, r_addr[31:2]} >= LP_DEPTH);

  // Stall covers the whole pending window, dropping in the Ready cycle so
  // the CPU advances on the edge that ends DONE.
  assign bus.Stall         = w_req & ~r_ready;
  assign bus.Ready         = r_ready;
  assign bus.AddrError     = r_addr_err;
  assign bus.Data_from_RAM = r_dout;

  // Next-state decode for the IDLE -> BUSY -> DONE handshake.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req) w_next_state = ST_BUSY;
        else       w_next_state = ST_IDLE;
      end
      ST_BUSY: begin
        if (r_cnt == 4'd0) w_next_state = ST_DONE;
        else               w_next_state = ST_BUSY;
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State, request latch, wait counter and registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_dout     <= 32'd0;
      r_ready    <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_ready    <= w_access;
      r_addr_err <= w_access & w_err;
      if ((r_state == ST_IDLE) && w_req) begin
        r_addr  <= bus.RAM_Address;
        r_wdata <= bus.Data_to_RAM;
        r_rd    <= bus.MemRead;
        r_wr    <= bus.MemWrite;
        r_cnt   <= LP_WAIT;
      end else if ((r_state == ST_BUSY) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access) begin
        if (w_err)     r_dout <= 32'd0;
        else if (r_rd) r_dout <= r_mem[w_index];
      end
    end
  end

  // Array write port; contents survive reset, and a reset on the access
  // edge abandons the store.
  always_ff @(posedge clk) begin
    if (!reset && w_access && r_wr && !w_err) begin
      r_mem[w_index] <= r_wdata;
    end
  end

endmodule
